// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename/ROB constants and tag types
// Purpose: common definitions used by the free list, rename stage and ROB.
// Contents: physical/architectural register counts, rename width, free-list
//           window size, tag typedefs and the free-list pointer type.
package rename_pkg;

  localparam int NUM_PHYS     = 64;
  localparam int NUM_ARCH     = 32;
  localparam int RENAME_WIDTH = 4;
  localparam int FREE_WINDOW  = 16;
  localparam int FL_DEPTH     = NUM_PHYS - NUM_ARCH;

  typedef logic [5:0] phys_tag_t;
  typedef logic [4:0] arch_tag_t;

  // 5 index bits plus 1 wrap bit, so full (32) and empty (0) are distinct.
  typedef logic [5:0] fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - rename/commit bus of the physical register free list
// Purpose: groups the allocation, commit and window signals of the free list.
// Signals:
//   alloc_count        tags rename consumes this cycle (0..4)
//   commit_free_valid  per-lane valid for released tags
//   commit_free_reg    old destination tags released at commit
//   commit_alloc_count retired instructions with rd!=0 this cycle (0..4)
//   flush              discard all speculative allocations
//   free_regs_out      window of free tags, entry k = fifo[head+k]
//   free_regs_valid    min(free_count,15)
//   free_count         exact number of free tags (0..32)
//   empty              free_count==0
//   err                one-cycle protocol violation pulse
// Modports: master = rename/ROB side, slave = free list.
interface phys_reg_free_list_if;
  import rename_pkg::*;

  logic [2:0]              alloc_count;
  logic [RENAME_WIDTH-1:0] commit_free_valid;
  phys_tag_t               commit_free_reg [RENAME_WIDTH];
  logic [2:0]              commit_alloc_count;
  logic                    flush;

  phys_tag_t               free_regs_out [FREE_WINDOW];
  logic [3:0]              free_regs_valid;
  logic [5:0]              free_count;
  logic                    empty;
  logic                    err;

  modport master (
    output alloc_count, commit_free_valid, commit_free_reg,
           commit_alloc_count, flush,
    input  free_regs_out, free_regs_valid, free_count, empty, err
  );

  modport slave (
    input  alloc_count, commit_free_valid, commit_free_reg,
           commit_alloc_count, flush,
    output free_regs_out, free_regs_valid, free_count, empty, err
  );

endinterface

// File: rtl/free_lane_compactor.sv
// rtl/free_lane_compactor.sv - packs valid, non-zero commit-free lanes into a dense list
// Purpose: combinational compaction of the released tags in lane order
//          (lane 0 first); tag 0 is hard-wired x0 and is filtered out.
// Ports:
//   i_valid    per-lane valid
//   i_tag      per-lane released tag
//   o_tag      dense list, entries >= o_count are 0
//   o_count    number of kept tags (0..4)
//   o_dropped  a valid lane carried tag 0 and was discarded
module free_lane_compactor
  import rename_pkg::*;
(
  input  logic [RENAME_WIDTH-1:0] i_valid,
  input  phys_tag_t               i_tag [RENAME_WIDTH],
  output phys_tag_t               o_tag [RENAME_WIDTH],
  output logic [2:0]              o_count,
  output logic                    o_dropped
);

  always_comb begin
    o_count   = '0;
    o_dropped = 1'b0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      o_tag[i] = '0;
    end
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (i_valid[i]) begin
        if (i_tag[i] != '0) begin
          o_tag[o_count[1:0]] = i_tag[i];
          o_count             = o_count + 3'd1;
        end else begin
          o_dropped = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical register tags for rename
// Purpose: holds the 32 free physical tags, exposes a 16-entry window to
//          rename, takes back up to 4 released tags per cycle from commit and
//          rolls speculative allocations back to the committed pointer on flush.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    free-list bus (slave side), see phys_reg_free_list_if
module phys_reg_free_list
  import rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  phys_reg_free_list_if.slave  bus
);

  phys_tag_t  r_fifo [FL_DEPTH];
  fl_ptr_t    r_head;    // allocation pointer (speculative)
  fl_ptr_t    r_chead;   // committed-allocation pointer
  fl_ptr_t    r_tail;    // free pointer
  logic       r_err;

  logic [5:0] w_free_count;
  logic [5:0] w_alloc_ext;
  logic       w_alloc_err;
  logic [5:0] w_outstanding;
  logic [5:0] w_cac_ext;
  logic       w_clamp_err;
  fl_ptr_t    w_chead_next;
  fl_ptr_t    w_head_next;
  phys_tag_t  w_free_tags [RENAME_WIDTH];
  logic [2:0] w_free_cnt;
  logic       w_zero_drop;
  logic [6:0] w_occupancy;
  logic       w_full_err;
  fl_ptr_t    w_tail_next;
  logic [4:0] w_wr_idx [RENAME_WIDTH];

  free_lane_compactor u_compactor (
    .i_valid   (bus.commit_free_valid),
    .i_tag     (bus.commit_free_reg),
    .o_tag     (w_free_tags),
    .o_count   (w_free_cnt),
    .o_dropped (w_zero_drop)
  );

  always_comb begin
    w_free_count  = r_tail - r_head;
    w_alloc_ext   = {3'b000, bus.alloc_count};
    // alloc_count is ignored entirely in a flush cycle
    w_alloc_err   = !bus.flush &&
                    ((bus.alloc_count > 3'd4) || (w_alloc_ext > w_free_count));

    // chead may never overtake head; if the ROB retires more than is
    // outstanding, clamp to head instead of corrupting the pointer order.
    w_outstanding = r_head - r_chead;
    w_cac_ext     = {3'b000, bus.commit_alloc_count};
    w_clamp_err   = w_cac_ext > w_outstanding;
    w_chead_next  = w_clamp_err ? r_head : r_chead + w_cac_ext;

    if (bus.flush) begin
      w_head_next = w_chead_next;
    end else if (w_alloc_err) begin
      w_head_next = r_head;
    end else begin
      w_head_next = r_head + w_alloc_ext;
    end

    // Entries owned by the list after this cycle: free ones plus those still
    // speculatively allocated. More than 32 means a tag is being freed twice.
    w_occupancy = {1'b0, r_tail - w_chead_next} + {4'b0000, w_free_cnt};
    w_full_err  = w_occupancy > 7'd32;
    w_tail_next = w_full_err ? r_tail : r_tail + {3'b000, w_free_cnt};

    for (int j = 0; j < RENAME_WIDTH; j++) begin
      w_wr_idx[j] = r_tail[4:0] + 5'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_fifo[i] <= phys_tag_t'(NUM_ARCH + i);
      end
      r_head  <= '0;
      r_chead <= '0;
      r_tail  <= fl_ptr_t'(FL_DEPTH);
      r_err   <= 1'b0;
    end else begin
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        if (!w_full_err && (3'(j) < w_free_cnt)) begin
          r_fifo[w_wr_idx[j]] <= w_free_tags[j];
        end
      end
      r_head  <= w_head_next;
      r_chead <= w_chead_next;
      r_tail  <= w_tail_next;
      r_err   <= w_alloc_err | w_clamp_err | w_zero_drop | w_full_err;
    end
  end

  // Window and status depend only on registered state, so a write this cycle
  // (including a free into an empty list) shows up one cycle later.
  always_comb begin
    for (int k = 0; k < FREE_WINDOW; k++) begin
      if (6'(k) < w_free_count) begin
        bus.free_regs_out[k] = r_fifo[r_head[4:0] + 5'(k)];
      end else begin
        bus.free_regs_out[k] = '0;
      end
    end
    bus.free_regs_valid = (w_free_count > 6'd15) ? 4'd15 : w_free_count[3:0];
    bus.free_count      = w_free_count;
    bus.empty           = (w_free_count == 6'd0);
    bus.err             = r_err;
  end

  a_no_over_free: assert property (@(posedge clk) disable iff (reset) !w_full_err);

endmodule
